reservation_station: RTL and testbench
======================================

# reservation_station

Out-of-order issue queue between dispatch and one functional unit. It accepts renamed, dispatched micro-ops and holds them until both source physical registers are ready. Entries capture wakeup broadcasts from the writeback/CDB. Each cycle it issues the oldest ready entry to its FU through a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 8: number of entries. Must equal 2^width of `rs_data.age` (3 bits → 8).
- `NUM_WAKEUP`, 3: number of wakeup broadcast ports, one per FU writeback.
- `PREG_W`, 7: physical register tag width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  mispredict flush; discards all entries.
- `disp_valid`  in  1  dispatch offers an op.
- `disp_ready`  out  1  RS can accept an op.
- `disp_data`  in  `dispatch_pipeline_data`  op; `pr1_ready`/`pr2_ready` reflect the busy table at dispatch.
- `disp_fu`  in  2  FU class, stored in `rs_data.fu`.
- `wk_valid`  in  NUM_WAKEUP  wakeup strobes.
- `wk_prd`  in  NUM_WAKEUP*PREG_W  woken tags; port i is bits [i*7 +: 7].
- `issue_valid`  out  1  `issue_data` holds a ready op.
- `issue_ready`  in  1  FU accepts this cycle.
- `issue_data`  out  `rs_data`  selected entry, with `valid`=1 and current ready bits.
- `free_count`  out  $clog2(DEPTH+1)  number of empty entries.

## Operation
- Each entry is one `rs_data` record. `valid`=0 means the entry is free.
- Allocate: when `disp_valid & disp_ready`, write into the lowest-index free entry.
  - Copy Opcode, prd, pr1, pr2, imm, rob_index from `disp_data`, and fu from `disp_fu`.
  - Set `age`=0.
- Source ready on insert = `disp_data.prX_ready` OR (prX==0) OR any `wk_valid[i]` with `wk_prd[i]==prX` in the same cycle. This coincident-wakeup capture is mandatory.
- Wakeup: for every valid entry, a matching `wk_valid[i]/wk_prd[i]` sets `pr1_ready` and/or `pr2_ready`. Ready bits never clear except on free.
- Age (keeps valid ages unique, 0..count-1):
  - On allocate, every other valid entry increments its age.
  - On issue of the entry with age A, every entry with age > A decrements.
  - Both rules apply in the same cycle (net change 0 where both hit).
- Select: among valid entries with both ready bits set, pick the maximum age (oldest). Ties are impossible.
- `issue_valid` = any selectable entry AND !`flush`.
- On `issue_valid & issue_ready`, the selected entry is freed at the edge.
- `disp_ready` = (`free_count` != 0) AND !`reset`. It is computed from registered state, so the slot freed by a same-cycle issue is not reusable until the next cycle.
- `flush`: at the edge, all `valid` bits clear and the dispatch write is dropped. Flush has priority over dispatch, issue and wakeup.
- `reset`: same effect as flush. Reset values: all entries invalid, `issue_valid`=0, `free_count`=DEPTH, `disp_ready`=0 while `reset` is high and 1 afterwards.

## Timing
- Dispatch accepted at edge N (op fully ready) → `issue_valid` high in cycle N+1 at the earliest.
- Wakeup in cycle N → issue eligible in cycle N+1. With `RS_WAKEUP_ISSUE_EN`, the op is eligible in cycle N itself.
- `issue_data` and `issue_valid` are combinational from registered entries plus the (optional) same-cycle wakeup; there are no combinational paths from `issue_ready`.
- Holding `issue_ready`=0 keeps the same entry selected unless an older entry becomes ready.
- Sustained throughput: one issue and one dispatch per cycle.

## Configuration
- `RS_WAKEUP_ISSUE_EN` defined: selection uses ready bits OR'd with this cycle's wakeup matches (zero-cycle wakeup-to-issue).
- `RS_WAKEUP_ISSUE_EN` undefined: selection uses only registered ready bits (one-cycle bubble, shorter critical path).
- Allocate, wakeup-capture and age rules are identical in both builds.

## Structure
- In `types_pkg`:
  - `rs_data` and `dispatch_pipeline_data` (existing).
  - New constants `RS_DEPTH` = 8 and `PREG_W` = 7.
  - FU encodings `FU_ALU` = 2'd0, `FU_MEM` = 2'd1, `FU_BR` = 2'd2.
- One sub-module, `rs_select`: combinational oldest-ready picker.
  - Inputs: DEPTH eligible bits and DEPTH ages.
  - Outputs: one-hot grant and `any`.
- Allocate, wakeup, age update and flush logic stay in `reservation_station`.

## Test plan
- Reset high for 2 cycles, then low → `issue_valid`=0, `free_count`=8, `disp_ready`=1 in the first cycle after reset.
- Dispatch pr1=5 (ready), pr2=9 (not ready), rob_index=4; `wk_valid[1]` with tag 9 two cycles later → `issue_valid` the cycle after the wakeup (same cycle with macro), `issue_data.rob_index`=4, `pr2_ready`=1.
- Dispatch fully ready ops with rob_index 1, 2, 3 while `issue_ready`=0, then hold `issue_ready`=1 → issue order 1, 2, 3, then `free_count` returns to 8.
- Dispatch 8 ready ops → `disp_ready`=0 and `free_count`=0. Issue one → `disp_ready`=1 next cycle. An 8-dispatch + 1-issue same-cycle edge case leaves `free_count`=1.
- Dispatch pr2=12 (not ready) in the same cycle as `wk_valid[0]` with tag 12 → entry stored with `pr2_ready`=1 and issues with no further wakeup.
- 4 entries valid, assert `flush` together with `disp_valid` and `issue_ready` → `issue_valid`=0 that cycle, `free_count`=8 next cycle, no issue handshake occurs.

Source files
------------

// File: rtl/types_pkg.sv
// Shared pipeline types: dispatch record, reservation-station entry, FU encodings.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package types_pkg;

    localparam int RS_DEPTH = 8;
    localparam int PREG_W   = 7;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_MEM = 2'd1;
    localparam logic [1:0] FU_BR  = 2'd2;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic              pr1_ready;
        logic [PREG_W-1:0] pr2;
        logic              pr2_ready;
        logic [31:0]       imm;
        logic [4:0]        rob_index;
    } dispatch_pipeline_data;

    typedef struct packed {
        logic              valid;
        logic [6:0]        opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic              pr1_ready;
        logic [PREG_W-1:0] pr2;
        logic              pr2_ready;
        logic [31:0]       imm;
        logic [4:0]        rob_index;
        logic [2:0]        age;
        logic [1:0]        fu;
    } rs_data;

endpackage

// File: rtl/rs_select.sv
// Oldest-ready picker: one-hot grant of the eligible entry with the largest age.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rs_select #(
    parameter int DEPTH = 8,
    parameter int AGE_W = 3
) (
    input  logic [DEPTH-1:0]            eligible,
    input  logic [DEPTH-1:0][AGE_W-1:0] age,
    output logic [DEPTH-1:0]            grant,
    output logic                        any
);

    logic [AGE_W-1:0] best_age;

    // Linear scan keeping the largest age seen; valid ages are unique so no tie-break is needed.
    always_comb begin
        grant    = '0;
        any      = 1'b0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (eligible[i] && (!any || (age[i] > best_age))) begin
                grant    = '0;
                grant[i] = 1'b1;
                any      = 1'b1;
                best_age = age[i];
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Issue queue holding dispatched ops until both sources are ready, then issuing oldest-ready first.
// Latency: dispatch->issue >= 1 cycle; wakeup->issue 1 cycle (0 with RS_WAKEUP_ISSUE_EN defined).
// Backpressure: disp_ready drops when all entries are full; issue_valid holds the pick until issue_ready.
module reservation_station
    import types_pkg::*;
#(
    parameter int DEPTH      = RS_DEPTH,
    parameter int NUM_WAKEUP = 3,
    parameter int PREG_W     = 7
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  dispatch_pipeline_data          disp_data,
    input  logic [1:0]                     disp_fu,
    input  logic [NUM_WAKEUP-1:0]          wk_valid,
    input  logic [NUM_WAKEUP*PREG_W-1:0]   wk_prd,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output rs_data                         issue_data,
    output logic [$clog2(DEPTH+1)-1:0]     free_count
);

    localparam int AGE_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    rs_data                      ent_q [DEPTH];
    rs_data                      new_ent;
    logic [DEPTH-1:0]            hit1, hit2, rdy1, rdy2, elig, grant;
    logic [DEPTH-1:0][AGE_W-1:0] ages;
    logic                        any_rdy;
    logic [AGE_W-1:0]            sel_age;
    logic [AGE_W-1:0]            alloc_idx;
    logic                        do_alloc, do_issue;

    function automatic logic wk_hit(input logic [PREG_W-1:0]            tag,
                                    input logic [NUM_WAKEUP-1:0]        vld,
                                    input logic [NUM_WAKEUP*PREG_W-1:0] prd);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_WAKEUP; i++)
            if (vld[i] && (prd[i*PREG_W +: PREG_W] == tag))
                hit = 1'b1;
        return hit;
    endfunction

    // Per-entry wakeup matches and selection eligibility (optionally including this cycle's wakeups).
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            hit1[e] = wk_hit(ent_q[e].pr1, wk_valid, wk_prd);
            hit2[e] = wk_hit(ent_q[e].pr2, wk_valid, wk_prd);
`ifdef RS_WAKEUP_ISSUE_EN
            rdy1[e] = ent_q[e].pr1_ready | hit1[e];
            rdy2[e] = ent_q[e].pr2_ready | hit2[e];
`else
            rdy1[e] = ent_q[e].pr1_ready;
            rdy2[e] = ent_q[e].pr2_ready;
`endif
            elig[e] = ent_q[e].valid & rdy1[e] & rdy2[e];
            ages[e] = ent_q[e].age;
        end
    end

    rs_select #(
        .DEPTH (DEPTH),
        .AGE_W (AGE_W)
    ) u_select (
        .eligible (elig),
        .age      (ages),
        .grant    (grant),
        .any      (any_rdy)
    );

    // Mux the granted entry onto the issue port with the ready bits that made it eligible.
    always_comb begin
        issue_data = '0;
        sel_age    = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (grant[e]) begin
                issue_data           = ent_q[e];
                issue_data.valid     = 1'b1;
                issue_data.pr1_ready = rdy1[e];
                issue_data.pr2_ready = rdy2[e];
                sel_age              = ent_q[e].age;
            end
        end
        issue_valid = any_rdy & ~flush;
        do_issue    = issue_valid & issue_ready;
    end

    // Free-slot count, lowest free index, and the record written on allocate.
    always_comb begin
        free_count = '0;
        alloc_idx  = '0;
        for (int e = DEPTH-1; e >= 0; e--) begin
            if (!ent_q[e].valid) begin
                free_count = free_count + CNT_W'(1);
                alloc_idx  = AGE_W'(e);
            end
        end
        disp_ready = (free_count != '0) && !reset;
        do_alloc   = disp_valid & disp_ready & ~flush;

        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.opcode    = disp_data.opcode;
        new_ent.prd       = disp_data.prd;
        new_ent.pr1       = disp_data.pr1;
        new_ent.pr2       = disp_data.pr2;
        new_ent.pr1_ready = disp_data.pr1_ready | (disp_data.pr1 == '0) |
                            wk_hit(disp_data.pr1, wk_valid, wk_prd);
        new_ent.pr2_ready = disp_data.pr2_ready | (disp_data.pr2 == '0) |
                            wk_hit(disp_data.pr2, wk_valid, wk_prd);
        new_ent.imm       = disp_data.imm;
        new_ent.rob_index = disp_data.rob_index;
        new_ent.age       = '0;
        new_ent.fu        = disp_fu;
    end

    // Entry state: flush/reset clear all, issue frees, allocate writes, wakeups set ready, ages track order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int e = 0; e < DEPTH; e++)
                ent_q[e] <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (do_issue && grant[e]) begin
                    ent_q[e].valid <= 1'b0;
                end else if (do_alloc && (alloc_idx == AGE_W'(e))) begin
                    ent_q[e] <= new_ent;
                end else if (ent_q[e].valid) begin
                    ent_q[e].pr1_ready <= ent_q[e].pr1_ready | hit1[e];
                    ent_q[e].pr2_ready <= ent_q[e].pr2_ready | hit2[e];
                    ent_q[e].age       <= ent_q[e].age + AGE_W'(do_alloc)
                                        - AGE_W'(do_issue && (ent_q[e].age > sel_age));
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Randomized + directed bench comparing reservation_station against an in-order queue model.
// Latency: one model step per clock; outputs sampled 1 time unit after the falling edge.
// Backpressure: issue_ready and disp_valid are driven randomly or per directed scenario.
module tb_reservation_station;
    import types_pkg::*;

    localparam int DEPTH = 8;
    localparam int NW    = 3;
    localparam int PW    = 7;
`ifdef RS_WAKEUP_ISSUE_EN
    localparam logic SAME_CYCLE = 1'b1;
`else
    localparam logic SAME_CYCLE = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset, flush, disp_valid, disp_ready;
    dispatch_pipeline_data disp_data;
    logic [1:0]            disp_fu;
    logic [NW-1:0]         wk_valid;
    logic [NW*PW-1:0]      wk_prd;
    logic                  issue_valid, issue_ready;
    rs_data                issue_data;
    logic [3:0]            free_count;

    int errors = 0;
    int checks = 0;

    rs_data     mq[$];
    logic [4:0] issued_log[$];

    logic       s_iv, s_dr;
    logic [3:0] s_fc;
    rs_data     s_id;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(DEPTH), .NUM_WAKEUP(NW), .PREG_W(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_data   (disp_data),
        .disp_fu     (disp_fu),
        .wk_valid    (wk_valid),
        .wk_prd      (wk_prd),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_data  (issue_data),
        .free_count  (free_count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic wk_match(input logic [6:0] tag);
        for (int i = 0; i < NW; i++)
            if (wk_valid[i] && (wk_prd[i*PW +: PW] == tag))
                return 1'b1;
        return 1'b0;
    endfunction

    // Compare this cycle's outputs to the model, then advance the model across the edge.
    task automatic tick();
        int     sel;
        int     n;
        logic   r1, r2, exp_iv, exp_dr;
        rs_data ed, tmp, ne;
        #1;
        n   = mq.size();
        sel = -1;
        ed  = '0;
        for (int i = 0; i < n; i++) begin
            r1 = mq[i].pr1_ready;
            r2 = mq[i].pr2_ready;
            if (SAME_CYCLE) begin
                r1 = r1 | wk_match(mq[i].pr1);
                r2 = r2 | wk_match(mq[i].pr2);
            end
            if (sel < 0 && r1 && r2) begin
                sel          = i;
                ed           = mq[i];
                ed.valid     = 1'b1;
                ed.pr1_ready = r1;
                ed.pr2_ready = r2;
                ed.age       = 3'(n - 1 - i);
            end
        end
        exp_iv = (sel >= 0) && !flush;
        exp_dr = (n < DEPTH) && !reset;
        chk("free_count", 128'(free_count), 128'(DEPTH - n));
        chk("disp_ready", 128'(disp_ready), 128'(exp_dr));
        chk("issue_valid", 128'(issue_valid), 128'(exp_iv));
        if (exp_iv)
            chk("issue_data", 128'(issue_data), 128'(ed));
        s_iv = issue_valid;
        s_dr = disp_ready;
        s_fc = free_count;
        s_id = issue_data;
        if (issue_valid && issue_ready)
            issued_log.push_back(issue_data.rob_index);

        if (reset || flush) begin
            mq.delete();
        end else begin
            if (exp_iv && issue_ready)
                mq.delete(sel);
            for (int i = 0; i < mq.size(); i++) begin
                tmp = mq[i];
                if (wk_match(tmp.pr1)) tmp.pr1_ready = 1'b1;
                if (wk_match(tmp.pr2)) tmp.pr2_ready = 1'b1;
                mq[i] = tmp;
            end
            if (disp_valid && exp_dr) begin
                ne           = '0;
                ne.valid     = 1'b1;
                ne.opcode    = disp_data.opcode;
                ne.prd       = disp_data.prd;
                ne.pr1       = disp_data.pr1;
                ne.pr2       = disp_data.pr2;
                ne.pr1_ready = disp_data.pr1_ready || disp_data.pr1 == 7'd0 || wk_match(disp_data.pr1);
                ne.pr2_ready = disp_data.pr2_ready || disp_data.pr2 == 7'd0 || wk_match(disp_data.pr2);
                ne.imm       = disp_data.imm;
                ne.rob_index = disp_data.rob_index;
                ne.fu        = disp_fu;
                mq.push_back(ne);
            end
        end
        @(negedge clk);
    endtask

    task automatic set_disp(input logic [4:0] rob, input logic [6:0] p1, input logic r1,
                            input logic [6:0] p2, input logic r2);
        disp_valid          = 1'b1;
        disp_data.opcode    = 7'($urandom);
        disp_data.prd       = 7'($urandom);
        disp_data.pr1       = p1;
        disp_data.pr1_ready = r1;
        disp_data.pr2       = p2;
        disp_data.pr2_ready = r2;
        disp_data.imm       = $urandom;
        disp_data.rob_index = rob;
        disp_fu             = 2'($urandom_range(0, 2));
    endtask

    initial begin
        int nlog;
        reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_data = '0; disp_fu = FU_ALU;
        wk_valid = '0; wk_prd = '0; issue_ready = 1'b0;
        @(negedge clk);

        // Reset: two cycles high, then first cycle low.
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_issue_valid", 128'(s_iv), 128'(0));
        chk("rst_free_count", 128'(s_fc), 128'(8));
        chk("rst_disp_ready", 128'(s_dr), 128'(1));

        // Wakeup of pr2=9 on port 1 two cycles after dispatch.
        set_disp(5'd4, 7'd5, 1'b1, 7'd9, 1'b0);
        tick();
        disp_valid = 1'b0;
        tick();
        wk_valid = 3'b010;
        wk_prd   = '0;
        wk_prd[PW +: PW] = 7'd9;
        tick();
        chk("wk_cycle_issue_valid", 128'(s_iv), 128'(SAME_CYCLE));
        wk_valid = '0;
        tick();
        chk("wk_next_issue_valid", 128'(s_iv), 128'(1));
        chk("wk_rob_index", 128'(s_id.rob_index), 128'(4));
        chk("wk_pr2_ready", 128'(s_id.pr2_ready), 128'(1));
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // Oldest-first order with ready ops held back, then released.
        issued_log.delete();
        for (int r = 1; r <= 3; r++) begin
            set_disp(5'(r), 7'd1, 1'b1, 7'd2, 1'b1);
            tick();
        end
        disp_valid  = 1'b0;
        issue_ready = 1'b1;
        tick(); tick(); tick();
        issue_ready = 1'b0;
        tick();
        chk("order_free_count", 128'(s_fc), 128'(8));
        chk("order_count", 128'(issued_log.size()), 128'(3));
        for (int i = 0; i < 3; i++)
            chk($sformatf("order_%0d", i),
                128'((i < issued_log.size()) ? issued_log[i] : 5'h1f), 128'(i + 1));

        // Fill all 8 entries, then free one.
        for (int k = 0; k < 8; k++) begin
            set_disp(5'(10 + k), 7'd3, 1'b1, 7'd4, 1'b1);
            tick();
        end
        disp_valid = 1'b0;
        tick();
        chk("full_free_count", 128'(s_fc), 128'(0));
        chk("full_disp_ready", 128'(s_dr), 128'(0));
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        tick();
        chk("after_issue_disp_ready", 128'(s_dr), 128'(1));
        chk("after_issue_free_count", 128'(s_fc), 128'(1));

        // Eighth dispatch in the same cycle as one issue leaves one slot free.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 7; k++) begin
            set_disp(5'(k), 7'd3, 1'b1, 7'd4, 1'b1);
            tick();
        end
        set_disp(5'd7, 7'd3, 1'b1, 7'd4, 1'b1);
        issue_ready = 1'b1;
        tick();
        disp_valid  = 1'b0;
        issue_ready = 1'b0;
        tick();
        chk("edge_free_count", 128'(s_fc), 128'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Coincident wakeup captured on insert; pr1=0 counts as ready.
        set_disp(5'd20, 7'd0, 1'b0, 7'd12, 1'b0);
        wk_valid = 3'b001;
        wk_prd   = '0;
        wk_prd[0 +: PW] = 7'd12;
        tick();
        disp_valid = 1'b0;
        wk_valid   = '0;
        tick();
        chk("coinc_issue_valid", 128'(s_iv), 128'(1));
        chk("coinc_pr2_ready", 128'(s_id.pr2_ready), 128'(1));
        chk("coinc_pr1_ready", 128'(s_id.pr1_ready), 128'(1));
        chk("coinc_rob_index", 128'(s_id.rob_index), 128'(20));
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // Flush beats dispatch and issue.
        for (int k = 0; k < 4; k++) begin
            set_disp(5'(24 + k), 7'd5, 1'b1, 7'd6, 1'b1);
            tick();
        end
        set_disp(5'd30, 7'd5, 1'b1, 7'd6, 1'b1);
        flush       = 1'b1;
        issue_ready = 1'b1;
        nlog        = issued_log.size();
        tick();
        chk("flush_issue_valid", 128'(s_iv), 128'(0));
        chk("flush_no_handshake", 128'(issued_log.size()), 128'(nlog));
        flush       = 1'b0;
        disp_valid  = 1'b0;
        issue_ready = 1'b0;
        tick();
        chk("flush_free_count", 128'(s_fc), 128'(8));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 1)
                set_disp(5'($urandom), 7'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                         7'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
            else
                disp_valid = 1'b0;
            for (int i = 0; i < NW; i++) begin
                wk_valid[i]          = ($urandom_range(0, 4) < 2);
                wk_prd[i*PW +: PW]   = 7'($urandom_range(0, 15));
            end
            issue_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
